// File: rtl/text_glyph_pkg.sv
// Shared constants and types for the text-layer glyph writer.
// Glyph geometry, font ROM sizing and the writer FSM state type.
package text_glyph_pkg;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 8;
  localparam int FONT_CHARS = 128;
  localparam int FONT_AW    = $clog2(FONT_CHARS * GLYPH_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAW,
    ST_CLEAR
  } state_t;

  // Codes above the 7-bit font range draw the blank glyph of code 0x00.
  function automatic logic [6:0] render_code(input logic [7:0] code);
    return code[7] ? 7'd0 : code[6:0];
  endfunction

endpackage

// File: rtl/text_glyph_writer_if.sv
// Request and pixel-write port bundle of the text glyph writer.
// Requester owns the master side, the writer owns the slave side.
interface text_glyph_writer_if
  import text_glyph_pkg::*;
#(
  parameter int X_LIMIT = 240,
  parameter int Y_LIMIT = 240
);
  localparam int COL_W  = $clog2(X_LIMIT / GLYPH_W);
  localparam int ROW_W  = $clog2(Y_LIMIT / GLYPH_H);
  localparam int ADDR_W = $clog2(X_LIMIT) + $clog2(Y_LIMIT);

  // Valid/ready: a request transfers on the rising CLK edge where CHAR_VALID
  // and CHAR_READY are both high; the requester keeps CHAR_CODE/COL/ROW stable
  // from raising CHAR_VALID until that edge and may not withdraw it before.
  logic [7:0]        CHAR_CODE;
  logic [COL_W-1:0]  CHAR_COL;
  logic [ROW_W-1:0]  CHAR_ROW;
  logic              CHAR_VALID;
  logic              CHAR_READY;
  logic              CLEAR_REQ;
  logic [ADDR_W-1:0] WRITE_ROM_ADDRESS;
  logic              WRITE_ROM_DATA;
  logic              WRITE_ROM;
  logic              OOB_DROP;

  modport master (
    output CHAR_CODE, CHAR_COL, CHAR_ROW, CHAR_VALID, CLEAR_REQ,
    input  CHAR_READY, WRITE_ROM_ADDRESS, WRITE_ROM_DATA, WRITE_ROM, OOB_DROP
  );

  modport slave (
    input  CHAR_CODE, CHAR_COL, CHAR_ROW, CHAR_VALID, CLEAR_REQ,
    output CHAR_READY, WRITE_ROM_ADDRESS, WRITE_ROM_DATA, WRITE_ROM, OOB_DROP
  );

endinterface

// File: rtl/font_rom_8x8.sv
// 1024 x 8 glyph ROM, synchronous read with one cycle of latency.
// Address is {code[6:0], glyph_row}; codes without a resident glyph read blank.
module font_rom_8x8
  import text_glyph_pkg::*;
(
  input  logic               CLK,
  input  logic [FONT_AW-1:0] addr,
  output logic [GLYPH_W-1:0] data
);

  function automatic logic [GLYPH_W-1:0] glyph_line(input logic [FONT_AW-1:0] a);
    glyph_line = '0;
    case (a[FONT_AW-1:3])
      7'h01: glyph_line = a[0] ? 8'h55 : 8'hAA;
      7'h30: begin
        case (a[2:0])
          3'd0: glyph_line = 8'h3C;
          3'd1: glyph_line = 8'h66;
          3'd2: glyph_line = 8'h6E;
          3'd3: glyph_line = 8'h76;
          3'd4: glyph_line = 8'h66;
          3'd5: glyph_line = 8'h66;
          3'd6: glyph_line = 8'h3C;
          default: glyph_line = 8'h00;
        endcase
      end
      7'h41: begin
        case (a[2:0])
          3'd0: glyph_line = 8'h18;
          3'd1: glyph_line = 8'h3C;
          3'd2: glyph_line = 8'h66;
          3'd3: glyph_line = 8'h66;
          3'd4: glyph_line = 8'h7E;
          3'd5: glyph_line = 8'h66;
          3'd6: glyph_line = 8'h66;
          default: glyph_line = 8'h00;
        endcase
      end
      7'h7F: glyph_line = 8'hFF;
      default: glyph_line = 8'h00;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    data <= glyph_line(addr);
  end

endmodule

// File: rtl/text_glyph_writer.sv
// Draws 8x8 glyphs into the 1-bit text layer one pixel per cycle and
// zero-fills the whole layer on request; all outputs are registered.
module text_glyph_writer
  import text_glyph_pkg::*;
#(
  parameter int X_LIMIT = 240,
  parameter int Y_LIMIT = 240
) (
  input  logic                CLK,
  input  logic                RESET,
  text_glyph_writer_if.slave  bus,
  output state_t              dbg_state
);

  localparam int COLS   = X_LIMIT / GLYPH_W;
  localparam int ROWS   = Y_LIMIT / GLYPH_H;
  localparam int ADDR_W = $clog2(X_LIMIT) + $clog2(Y_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(X_LIMIT * Y_LIMIT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(X_LIMIT);
  localparam logic [ADDR_W-1:0] CELL_STEP  = ADDR_W'(GLYPH_H * X_LIMIT);

  state_t              state;
  logic [6:0]          code_q;
  logic [2:0]          glyph_row;
  logic [2:0]          bit_idx;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   col_base;
  logic [ADDR_W-1:0]   clr_addr;
  logic                clear_pend;
  logic                ready_q;
  logic                wr_q;
  logic                wr_data_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                oob_q;
  logic [GLYPH_W-1:0]  font_row;
  logic                req_oob;

  assign req_oob = (int'(bus.CHAR_COL) >= COLS) || (int'(bus.CHAR_ROW) >= ROWS);

  font_rom_8x8 u_font (
    .CLK  (CLK),
    .addr ({code_q, glyph_row}),
    .data (font_row)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      code_q     <= '0;
      glyph_row  <= '0;
      bit_idx    <= '0;
      row_base   <= '0;
      col_base   <= '0;
      clr_addr   <= '0;
      clear_pend <= 1'b0;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      wr_data_q  <= 1'b0;
      wr_addr_q  <= '0;
      oob_q      <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      wr_data_q <= 1'b0;
      oob_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A pending or same-cycle clear wins over a waiting character.
          if (clear_pend || bus.CLEAR_REQ) begin
            clear_pend <= 1'b0;
            ready_q    <= 1'b0;
            clr_addr   <= '0;
            state      <= ST_CLEAR;
          end else if (ready_q && bus.CHAR_VALID) begin
            ready_q   <= 1'b0;
            code_q    <= render_code(bus.CHAR_CODE);
            col_base  <= ADDR_W'({bus.CHAR_COL, 3'b000});
            row_base  <= ADDR_W'(bus.CHAR_ROW) * CELL_STEP;
            glyph_row <= '0;
            bit_idx   <= '0;
            if (req_oob) oob_q <= 1'b1;
            else         state <= ST_FETCH;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          state <= ST_DRAW;
        end
        ST_DRAW: begin
          wr_q      <= 1'b1;
          wr_data_q <= font_row[3'd7 - bit_idx];
          wr_addr_q <= row_base + col_base + ADDR_W'(bit_idx);
          bit_idx   <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (glyph_row == 3'd7) begin
              state <= ST_IDLE;
            end else begin
              glyph_row <= glyph_row + 3'd1;
              row_base  <= row_base + LINE_STEP;
              state     <= ST_FETCH;
            end
          end
        end
        ST_CLEAR: begin
          wr_q      <= 1'b1;
          wr_addr_q <= clr_addr;
          clr_addr  <= clr_addr + 1'b1;
          if (clr_addr == LAST_PIXEL) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (bus.CLEAR_REQ && state != ST_IDLE) clear_pend <= 1'b1;
    end
  end

  assign bus.CHAR_READY        = ready_q;
  assign bus.WRITE_ROM         = wr_q;
  assign bus.WRITE_ROM_DATA    = wr_data_q;
  assign bus.WRITE_ROM_ADDRESS = wr_addr_q;
  assign bus.OOB_DROP          = oob_q;
  assign dbg_state             = state;

endmodule

// File: tb/tb_text_glyph_writer.sv
// Bench for text_glyph_writer: directed scenarios plus random draw requests,
// every write checked against a glyph/address model with exact cycle timing.
module tb_text_glyph_writer;
  import text_glyph_pkg::*;

  localparam int XL  = 240;
  localparam int YL  = 240;
  localparam int PIX = XL * YL;

  localparam logic [7:0] FONT_A [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
  localparam logic [7:0] FONT_0 [8] = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
  localparam logic [7:0] CODES [10] = '{8'h00, 8'h01, 8'h30, 8'h41, 8'h7F, 8'h80, 8'hC1, 8'hFF, 8'hB0, 8'h55};

  typedef struct packed {
    logic        is_clr;
    logic        data;
    logic [15:0] addr;
    logic [31:0] when;
  } exp_t;

  logic   CLK = 1'b0;
  logic   RESET = 1'b1;
  state_t dbg_state;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   exp_q[$];
  int     oob_q[$];
  logic [16:0] wr_log[$];
  int     clr_base = 0;
  int     clr_first = -1;
  int     clr_last = -1;

  text_glyph_writer_if #(.X_LIMIT(XL), .Y_LIMIT(YL)) bus ();

  text_glyph_writer #(.X_LIMIT(XL), .Y_LIMIT(YL)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_font(input logic [7:0] code, input int r);
    logic [7:0] c;
    c = code[7] ? 8'h00 : code;
    case (c)
      8'h01:   return (r % 2 == 0) ? 8'hAA : 8'h55;
      8'h30:   return FONT_0[r];
      8'h41:   return FONT_A[r];
      8'h7F:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_glyph(input logic [7:0] code, input int col, input int row, input int e0);
    exp_t e;
    logic [7:0] fr;
    for (int r = 0; r < 8; r++) begin
      fr = model_font(code, r);
      for (int b = 0; b < 8; b++) begin
        e.is_clr = 1'b0;
        e.data   = fr[7-b];
        e.addr   = 16'((row * 8 + r) * XL + col * 8 + b);
        e.when   = 32'(e0 + 2 + 9 * r + b);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_clear();
    exp_t e;
    for (int i = 0; i < PIX; i++) begin
      e.is_clr = 1'b1;
      e.data   = 1'b0;
      e.addr   = 16'(i);
      e.when   = 32'(i);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge CLK) begin : cmp
    exp_t e;
    logic exp_oob;
    if (RESET) begin
      exp_q.delete();
      oob_q.delete();
    end else begin
      exp_oob = (oob_q.size() > 0) && (oob_q[0] == cyc);
      if (exp_oob) void'(oob_q.pop_front());
      check("oob_drop", 32'(bus.OOB_DROP), 32'(exp_oob));
      if (bus.WRITE_ROM) begin
        wr_log.push_back({bus.WRITE_ROM_ADDRESS, bus.WRITE_ROM_DATA});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got addr %0d expected no write (cycle %0d)",
                   bus.WRITE_ROM_ADDRESS, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_clr) begin
            if (e.when == 0) begin
              clr_base  = cyc;
              clr_first = cyc;
            end
            if (e.when == 32'(PIX - 1)) clr_last = cyc;
            check("clear_cycle", 32'(cyc), 32'(clr_base) + e.when);
          end else begin
            check("write_cycle", 32'(cyc), e.when);
          end
          check("write_addr", 32'(bus.WRITE_ROM_ADDRESS), 32'(e.addr));
          check("write_data", 32'(bus.WRITE_ROM_DATA), 32'(e.data));
          check("ready_while_writing", 32'(bus.CHAR_READY), 0);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (!e.is_clr && e.when <= 32'(cyc)) begin
          checks++;
          errors++;
          $display("FAIL missing_write got none expected addr %0d at cycle %0d", e.addr, e.when);
          void'(exp_q.pop_front());
        end else if (e.is_clr && e.when != 0) begin
          checks++;
          errors++;
          $display("FAIL clear_gap got none expected addr %0d (cycle %0d)", e.addr, cyc);
          while (exp_q.size() > 0 && exp_q[0].is_clr) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic send_char(input logic [7:0] code, input int col, input int row,
                           input bit chk, output int e0);
    int n;
    bit oob;
    @(negedge CLK);
    bus.CHAR_CODE  = code;
    bus.CHAR_COL   = 5'(col);
    bus.CHAR_ROW   = 5'(row);
    bus.CHAR_VALID = 1'b1;
    n = 0;
    while (!bus.CHAR_READY && n < 70000) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.CHAR_READY) begin
      check("accept_timeout", 32'(bus.CHAR_READY), 1);
      bus.CHAR_VALID = 1'b0;
      e0 = -1;
      return;
    end
    e0  = cyc + 1;
    oob = (col >= XL / 8) || (row >= YL / 8);
    if (oob) oob_q.push_back(e0);
    else     push_glyph(code, col, row, e0);
    @(negedge CLK);
    bus.CHAR_VALID = 1'b0;
    if (chk) begin
      n = 0;
      while (!bus.CHAR_READY && n < 200) begin
        @(negedge CLK);
        n++;
      end
      check("ready_return", 32'(cyc), 32'(e0 + (oob ? 1 : 73)));
    end
  endtask

  task automatic pulse_clear(input bit expect_clear);
    @(negedge CLK);
    bus.CLEAR_REQ = 1'b1;
    if (expect_clear) push_clear();
    @(negedge CLK);
    bus.CLEAR_REQ = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, g1, g2, base, n;
    logic [7:0] row0;
    logic any_one;
    bus.CHAR_CODE  = '0;
    bus.CHAR_COL   = '0;
    bus.CHAR_ROW   = '0;
    bus.CHAR_VALID = 1'b0;
    bus.CLEAR_REQ  = 1'b0;

    repeat (5) @(negedge CLK);
    check("rst_ready", 32'(bus.CHAR_READY), 0);
    check("rst_write", 32'(bus.WRITE_ROM), 0);
    check("rst_addr", 32'(bus.WRITE_ROM_ADDRESS), 0);
    check("rst_data", 32'(bus.WRITE_ROM_DATA), 0);
    check("rst_oob", 32'(bus.OOB_DROP), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_reset", 32'(bus.CHAR_READY), 1);

    // 'A' in the top-left cell
    base = wr_log.size();
    send_char(8'h41, 0, 0, 1'b1, e0);
    check("a00_count", 32'(wr_log.size() - base), 64);
    if (wr_log.size() >= base + 64) begin
      for (int b = 0; b < 8; b++) row0[7-b] = wr_log[base+b][0];
      check("a00_row0", 32'(row0), 32'h18);
      check("a00_first_addr", 32'(wr_log[base][16:1]), 0);
      check("a00_addr7", 32'(wr_log[base+7][16:1]), 7);
    end

    // bottom-right cell
    base = wr_log.size();
    send_char(8'h41, 29, 29, 1'b1, e0);
    check("a29_count", 32'(wr_log.size() - base), 64);
    if (wr_log.size() >= base + 64) begin
      check("a29_first_addr", 32'(wr_log[base][16:1]), 55912);
      check("a29_last_addr", 32'(wr_log[base+63][16:1]), 57599);
    end

    // out-of-range column
    base = wr_log.size();
    send_char(8'h41, 30, 0, 1'b1, e0);
    check("oob_count", 32'(wr_log.size() - base), 0);

    // high code renders blank
    base = wr_log.size();
    send_char(8'hC1, 2, 3, 1'b1, e0);
    check("c1_count", 32'(wr_log.size() - base), 64);
    any_one = 1'b0;
    for (int i = base; i < wr_log.size(); i++) any_one |= wr_log[i][0];
    check("c1_all_zero", 32'(any_one), 0);

    // random request stream
    for (int i = 0; i < 100; i++) begin
      n = $urandom_range(0, 3);
      repeat (n) @(negedge CLK);
      send_char(CODES[$urandom_range(0, 9)], $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, e0);
    end

    // clear during a draw, repeated pulse, then a queued request
    send_char(8'h30, 5, 7, 1'b0, g1);
    wait_cyc(g1 + 20);
    pulse_clear(1'b1);
    wait_cyc(g1 + 30);
    pulse_clear(1'b0);
    send_char(8'h01, 1, 2, 1'b1, g2);
    check("clear_first", 32'(clr_first), 32'(g1 + 74));
    check("clear_last", 32'(clr_last), 32'(g1 + 74 + PIX - 1));
    check("queued_accept", 32'(g2), 32'(g1 + 74 + PIX + 1));

    // reset in the middle of glyph row 3 with a clear pending
    send_char(8'h7F, 3, 4, 1'b0, e0);
    wait_cyc(e0 + 10);
    pulse_clear(1'b0);
    wait_cyc(e0 + 31);
    #2 RESET = 1'b1;
    #1 check("reset_async_write", 32'(bus.WRITE_ROM), 0);
    repeat (5) @(negedge CLK);
    check("reset2_ready", 32'(bus.CHAR_READY), 0);
    check("reset2_state", 32'(dbg_state), 32'(ST_IDLE));
    RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_reset2", 32'(bus.CHAR_READY), 1);
    send_char(8'h41, 10, 10, 1'b1, e0);

    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (20) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
